// File: rtl/maple_frame_checker.sv
// Maple frame checker: parses the 4-byte header, checks payload length and XOR CRC, strips the CRC byte.
// Latency: a byte leaves one cycle after the next byte of its frame (or the CRC byte) is accepted.
// Backpressure: s_tready = !m_tvalid || m_tready; a stalled output beat holds all m_* signals stable.
module maple_frame_checker #(
    parameter int unsigned MAX_LEN_WORDS = 255
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       m_tlast,
    output logic       m_tuser,
    output logic       frame_done,
    output logic [2:0] frame_status,
    output logic [7:0] frame_cmd
);

    typedef enum logic [1:0] {ST_HDR, ST_PAYLOAD, ST_CRC, ST_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  crc_q, crc_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        pend_vld_q, pend_vld_d;
    logic [7:0]  pend_dat_q, pend_dat_d;
    logic        out_vld_q, out_vld_d;
    logic [7:0]  out_dat_q, out_dat_d;
    logic        out_last_q, out_last_d;
    logic        out_user_q, out_user_d;
    logic        done_q, done_d;
    logic [2:0]  status_q, status_d;
    logic [7:0]  fcmd_q, fcmd_d;

    logic        accept;
    logic        fwd;
    logic [10:0] cnt_inc;
    logic [10:0] exp_cnt;
    logic [10:0] pay_last;
    logic        short_err;
    logic        len_err;
    logic        crc_err;

    // Ready is forced low while reset is held so nothing is taken during reset.
    assign s_tready  = aresetn & (~out_vld_q | m_tready);
    assign accept    = s_tvalid & s_tready;
    assign cnt_inc   = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    assign exp_cnt   = 11'd5 + {1'b0, len_q, 2'b00};
    assign pay_last  = 11'd3 + {1'b0, len_q, 2'b00};
    // Frame-level checks, evaluated against the byte carrying s_tlast.
    assign short_err = cnt_inc < 11'd5;
    assign len_err   = !short_err && ((cnt_inc != exp_cnt) || (32'(len_q) > MAX_LEN_WORDS));
    assign crc_err   = short_err || (s_tdata != crc_q);
    // Only header and payload bytes travel downstream; CRC-slot extras and drained bytes do not.
    assign fwd       = accept && !s_tlast && ((state_q == ST_HDR) || (state_q == ST_PAYLOAD));

    assign m_tdata      = out_dat_q;
    assign m_tvalid     = out_vld_q;
    assign m_tlast      = out_last_q;
    assign m_tuser      = out_user_q;
    assign frame_done   = done_q;
    assign frame_status = status_q;
    assign frame_cmd    = fcmd_q;

    // Next-state: parser FSM, pending/output byte pipeline and frame status.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        len_d      = len_q;
        cmd_d      = cmd_q;
        pend_vld_d = pend_vld_q;
        pend_dat_d = pend_dat_q;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_last_d = out_last_q;
        out_user_d = out_user_q;
        done_d     = 1'b0;
        status_d   = status_q;
        fcmd_d     = fcmd_q;

        if (out_vld_q && m_tready) begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
            out_user_d = 1'b0;
        end

        if (accept) begin
            cnt_d = cnt_inc;
            if (s_tlast) begin
                // CRC byte: close the frame, tag the held byte as last, never forward the CRC.
                state_d    = ST_HDR;
                cnt_d      = 11'd0;
                crc_d      = 8'd0;
                len_d      = 8'd0;
                cmd_d      = 8'd0;
                pend_vld_d = 1'b0;
                if (pend_vld_q) begin
                    out_vld_d  = 1'b1;
                    out_dat_d  = pend_dat_q;
                    out_last_d = 1'b1;
                    out_user_d = crc_err | len_err | short_err;
                end
                done_d   = 1'b1;
                status_d = {crc_err, len_err, short_err};
                fcmd_d   = cmd_q;
            end else begin
                case (state_q)
                    ST_HDR: begin
                        if (cnt_q == 11'd0) len_d = s_tdata;
                        if (cnt_q == 11'd3) begin
                            cmd_d   = s_tdata;
                            state_d = (len_q == 8'd0) ? ST_CRC : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (cnt_q == pay_last) state_d = ST_CRC;
                    end
                    ST_CRC:   state_d = ST_DRAIN;
                    default:  state_d = ST_DRAIN;
                endcase
                if (fwd) begin
                    if (pend_vld_q) begin
                        out_vld_d  = 1'b1;
                        out_dat_d  = pend_dat_q;
                        out_last_d = 1'b0;
                        out_user_d = 1'b0;
                    end
                    pend_vld_d = 1'b1;
                    pend_dat_d = s_tdata;
                    crc_d      = crc_q ^ s_tdata;
                end
            end
        end
    end

    // State registers; reset discards any partial frame immediately.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_HDR;
            cnt_q      <= 11'd0;
            crc_q      <= 8'd0;
            len_q      <= 8'd0;
            cmd_q      <= 8'd0;
            pend_vld_q <= 1'b0;
            pend_dat_q <= 8'd0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= 8'd0;
            out_last_q <= 1'b0;
            out_user_q <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= 3'd0;
            fcmd_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            len_q      <= len_d;
            cmd_q      <= cmd_d;
            pend_vld_q <= pend_vld_d;
            pend_dat_q <= pend_dat_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_last_q <= out_last_d;
            out_user_q <= out_user_d;
            done_q     <= done_d;
            status_q   <= status_d;
            fcmd_q     <= fcmd_d;
        end
    end

endmodule

// File: doc/maple_frame_checker.md
Name: maple_frame_checker

Overview:
- Sits directly downstream of the Maple Bus receiver and consumes its byte-wide AXI-Stream output.
- Parses the 4-byte Maple frame header and checks the payload length against the header length field.
- Verifies the trailing XOR CRC byte and strips it.
- Forwards header and payload bytes downstream with TLAST moved onto the last payload byte, error-tagged via TUSER, and reports a per-frame status pulse.

Parameters:
- MAX_LEN_WORDS, 255, largest accepted header length field in 32-bit words; larger values are flagged as length errors.

Ports:
- aclk  input  1  clock
- aresetn  input  1  reset, asynchronous, active-low
- s_tdata  input  8  byte from receiver
- s_tvalid  input  1  input byte valid
- s_tready  output  1  checker can accept a byte
- s_tlast  input  1  input byte is last of frame (the CRC byte)
- m_tdata  output  8  forwarded header/payload byte
- m_tvalid  output  1  output byte valid
- m_tready  input  1  downstream accepts
- m_tlast  output  1  last forwarded byte of frame
- m_tuser  output  1  on the m_tlast beat: 1 = frame failed a check
- frame_done  output  1  one-cycle pulse when a frame's checks complete
- frame_status  output  3  {crc_err, len_err, short_err}, valid when frame_done=1, held otherwise
- frame_cmd  output  8  command byte of last completed frame, held

Behaviour:
- Reset values: s_tready=0 while aresetn=0 and 1 after; m_tvalid, m_tlast, m_tuser, frame_done = 0; frame_status = 0; frame_cmd = 0; all internal state cleared.
- Wire format: byte0=length L (words), byte1=sender, byte2=recipient, byte3=command, then 4*L payload bytes, then 1 CRC byte. Expected total is 5+4*L bytes.
- CRC: XOR of every byte before the CRC byte. The accumulator resets to 0 at frame start.
- Byte counter: 11 bits, saturating at 2047. It counts accepted bytes and resets on each accepted s_tlast.
- Transfer rule: a byte transfers when valid and ready are both 1 on the rising edge.
- Buffering: one pending register plus one output register. s_tready = !m_tvalid || m_tready.
- Each accepted non-last byte pushes the previous pending byte into the output register with m_tlast=0, then becomes the new pending byte.
- When the accepted byte has s_tlast=1:
  - that byte is compared with the accumulator and is never forwarded;
  - the pending byte, if present, moves to the output with m_tlast=1 and m_tuser = OR of the three error bits;
  - frame_done pulses on the cycle after acceptance and frame_status/frame_cmd update at the same time.
- Latency: a byte appears on m_tdata no earlier than 1 cycle after the next byte of the same frame is accepted.
- State machine:
  - HDR: bytes 0-3. Latch L at byte0 and the command at byte3. At byte3 go to PAYLOAD, or to CRC if L=0.
  - PAYLOAD: count 4*L bytes, then go to CRC.
  - CRC: the next byte is expected to carry s_tlast. Any extra bytes before s_tlast go to DRAIN.
  - DRAIN: bytes are accepted and discarded (not forwarded, not XORed). Sets len_err.
  - Any s_tlast in any state returns to HDR.
- Errors:
  - short_err: s_tlast arrives with count < 5.
  - len_err: count ≠ 5+4*L, or L > MAX_LEN_WORDS.
  - crc_err: CRC byte ≠ accumulator. Always set when short_err is set.
- Early s_tlast: if s_tlast arrives before the expected position, the remaining pending byte is tagged m_tlast=1, m_tuser=1.
- Single-byte frame (s_tlast on byte0): nothing is forwarded; frame_done still pulses with short_err=1, crc_err=1.
- Backpressure: m_tvalid, m_tdata, m_tlast and m_tuser hold stable while m_tvalid=1 and m_tready=0. No byte is dropped or duplicated.
- Frame boundary: frame n's last output and frame n+1's byte0 may be accepted back-to-back with no idle cycle.
- Reset asserted mid-frame: all state is discarded immediately, and the partial frame produces no m_tlast and no frame_done.

Test Plan:
- L=1 frame 01 20 00 09 AA BB CC DD 28(tlast), m_tready=1 → 8 bytes out, m_tlast on DD, m_tuser=0, frame_done once, frame_status=000, frame_cmd=09.
- L=0 frame 00 20 00 01 21(tlast) → 4 bytes out, m_tlast on 01, m_tuser=0, status=000.
- Same L=1 frame with CRC byte 29 → same 8 bytes, m_tuser=1 on DD, status=100.
- Header 02 20 00 09 then 4 payload bytes, then correct-XOR byte with tlast → m_tlast on 4th payload byte, m_tuser=1, len_err=1.
- L=1 frame with m_tready toggling 1 0 0 1 per cycle → output byte sequence identical to scenario 1, every held beat stable, s_tready low whenever the output register is full and stalled.
- Single byte 05 with tlast, then a valid L=0 frame back-to-back → first: no output, status=101; second: 4 bytes out, status=000.
- aresetn pulsed low after 3 bytes of a frame → outputs return to reset values immediately; the next full frame passes cleanly.
